// File: rtl/act_sequencer_pkg.sv
// Shared definitions for act_sequencer: FSM state encoding, FIFO depth and
// default widths.
package act_sequencer_pkg;

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StRun  = 2'd1,
    StDone = 2'd2
  } state_e;

  localparam int unsigned FifoDepth    = 2;
  localparam int unsigned DefaultAddrW = 10;
  localparam int unsigned DefaultDataW = 32;

endpackage

// File: rtl/act_sequencer_relu.sv
// relu_stage: combinational sign-bit clamp; negative two's-complement words
// become zero, non-negative words pass through.
module relu_stage
  import act_sequencer_pkg::*;
#(
  parameter int unsigned DATA_W = DefaultDataW
) (
  input  logic [DATA_W-1:0] data_i,
  output logic [DATA_W-1:0] data_o
);

  assign data_o = data_i[DATA_W-1] ? '0 : data_i;

endmodule

// File: rtl/act_sequencer.sv
// act_sequencer: streams len words from a source memory through a ReLU clamp
// into a destination port. Define ACT_NEGCOUNT_EN to add the neg_count output.
module act_sequencer
  import act_sequencer_pkg::*;
#(
  parameter int unsigned ADDR_W = DefaultAddrW,
  parameter int unsigned DATA_W = DefaultDataW
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [ADDR_W-1:0] src_base,
  input  logic [ADDR_W-1:0] dst_base,
  input  logic [ADDR_W-1:0] len,
  output logic              rd_en,
  output logic [ADDR_W-1:0] rd_addr,
  input  logic [DATA_W-1:0] rd_data,
  output logic              wr_valid,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [DATA_W-1:0] wr_data,
  input  logic              wr_ready,
  output logic              busy,
  output logic              done
`ifdef ACT_NEGCOUNT_EN
  ,
  output logic [ADDR_W:0]   neg_count
`endif
);

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] src_q, src_d, dst_q, dst_d, len_q, len_d;
  logic [ADDR_W-1:0] rd_idx_q, rd_idx_d, wr_idx_q, wr_idx_d;
  logic              inflight_q, inflight_d;

  logic [DATA_W-1:0] fifo_q [FifoDepth];
  logic              head_q, head_d, tail_q, tail_d;
  logic [1:0]        count_q, count_d;

  logic [DATA_W-1:0] relu_out, head_data;
  logic              fifo_empty, rd_go, wr_go, accept, push, pop, last_write;

  relu_stage #(
    .DATA_W(DATA_W)
  ) u_relu (
    .data_i(rd_data),
    .data_o(relu_out)
  );

  assign fifo_empty = (count_q == 2'd0);
  // A read is only issued if its word is guaranteed a FIFO slot on arrival.
  assign rd_go      = (state_q == StRun) && (rd_idx_q < len_q) &&
                      (({1'b0, count_q} + {2'b00, inflight_q}) < 3'(FifoDepth));
  // The arriving word is visible at the head when the FIFO is empty, so a
  // ready destination takes it without a bubble.
  assign wr_go      = (state_q == StRun) && (!fifo_empty || inflight_q);
  assign head_data  = fifo_empty ? relu_out : fifo_q[head_q];
  assign accept     = wr_go && wr_ready;
  assign push       = inflight_q && !(fifo_empty && accept);
  assign pop        = accept && !fifo_empty;
  assign last_write = (wr_idx_q == len_q - ADDR_W'(1));

  always_comb begin
    state_d    = state_q;
    src_d      = src_q;
    dst_d      = dst_q;
    len_d      = len_q;
    rd_idx_d   = rd_idx_q;
    wr_idx_d   = wr_idx_q;
    inflight_d = rd_go;
    case (state_q)
      StIdle: begin
        if (start) begin
          if (len != '0) begin
            src_d    = src_base;
            dst_d    = dst_base;
            len_d    = len;
            rd_idx_d = '0;
            wr_idx_d = '0;
            state_d  = StRun;
          end else begin
            state_d = StDone;
          end
        end
      end
      StRun: begin
        if (rd_go) rd_idx_d = rd_idx_q + ADDR_W'(1);
        if (accept) begin
          wr_idx_d = wr_idx_q + ADDR_W'(1);
          if (last_write) state_d = StDone;
        end
      end
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;
    if (push) tail_d = ~tail_q;
    if (pop)  head_d = ~head_q;
    if (push && !pop) count_d = count_q + 2'd1;
    else if (pop && !push) count_d = count_q - 2'd1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= StIdle;
      src_q      <= '0;
      dst_q      <= '0;
      len_q      <= '0;
      rd_idx_q   <= '0;
      wr_idx_q   <= '0;
      inflight_q <= 1'b0;
      head_q     <= 1'b0;
      tail_q     <= 1'b0;
      count_q    <= 2'd0;
      fifo_q[0]  <= '0;
      fifo_q[1]  <= '0;
    end else begin
      state_q    <= state_d;
      src_q      <= src_d;
      dst_q      <= dst_d;
      len_q      <= len_d;
      rd_idx_q   <= rd_idx_d;
      wr_idx_q   <= wr_idx_d;
      inflight_q <= inflight_d;
      head_q     <= head_d;
      tail_q     <= tail_d;
      count_q    <= count_d;
      if (push) fifo_q[tail_q] <= relu_out;
    end
  end

  // Outputs are forced to zero while reset is asserted, not just after it.
  assign rd_en    = rd_go && !rst;
  assign rd_addr  = rd_en ? src_q + rd_idx_q : '0;
  assign wr_valid = wr_go && !rst;
  assign wr_addr  = wr_valid ? dst_q + wr_idx_q : '0;
  assign wr_data  = wr_valid ? head_data : '0;
  assign busy     = (state_q != StIdle) && !rst;
  assign done     = (state_q == StDone) && !rst;

`ifdef ACT_NEGCOUNT_EN
  logic [ADDR_W:0] neg_q, neg_d;

  always_comb begin
    neg_d = neg_q;
    if (state_q == StIdle && start) neg_d = '0;
    else if (inflight_q && rd_data[DATA_W-1]) neg_d = neg_q + (ADDR_W + 1)'(1);
  end

  always_ff @(posedge clk) begin
    if (rst) neg_q <= '0;
    else     neg_q <= neg_d;
  end

  assign neg_count = neg_q;
`endif

endmodule

// File: tb/tb_act_sequencer.sv
// Self-checking bench for act_sequencer: queue-based reference model plus
// directed scenarios with hand-computed expectations.
module tb_act_sequencer;

  localparam int AW = 10;
  localparam int DW = 32;

  logic          clk = 1'b0;
  logic          rst, start, wr_ready;
  logic [AW-1:0] src_base, dst_base, len;
  logic          rd_en, wr_valid, busy, done;
  logic [AW-1:0] rd_addr, wr_addr;
  logic [DW-1:0] rd_data, wr_data;
`ifdef ACT_NEGCOUNT_EN
  logic [AW:0]   neg_count;
`endif

  act_sequencer #(
    .ADDR_W(AW),
    .DATA_W(DW)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .src_base (src_base),
    .dst_base (dst_base),
    .len      (len),
    .rd_en    (rd_en),
    .rd_addr  (rd_addr),
    .rd_data  (rd_data),
    .wr_valid (wr_valid),
    .wr_addr  (wr_addr),
    .wr_data  (wr_data),
    .wr_ready (wr_ready),
    .busy     (busy),
    .done     (done)
`ifdef ACT_NEGCOUNT_EN
    ,
    .neg_count(neg_count)
`endif
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic [DW-1:0] mem [1 << AW];
  always @(posedge clk) if (rd_en) rd_data <= mem[rd_addr];

  int ready_mode = 0;
  always @(posedge clk) begin
    #1;
    wr_ready = (ready_mode == 0) ? 1'b1 : ((cyc % 2) == 0);
  end

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic logic [DW-1:0] relu_ref(input logic [DW-1:0] w);
    return ($signed(w) < 0) ? '0 : w;
  endfunction

  // Reference model state
  logic [AW-1:0] exp_rd[$];
  logic [AW-1:0] exp_wa[$];
  logic [DW-1:0] exp_wd[$];
  int            exp_neg;
  logic [AW-1:0] rd_log_addr[$];
  int            rd_log_cyc[$];
  logic [AW-1:0] wr_log_addr[$];
  logic [DW-1:0] wr_log_data[$];
  int            wr_log_cyc[$];
  int            reads, accepts, first_wv_cyc, done_cyc, start_cyc;
  int            done_count = 0;
  logic          prev_stall = 1'b0;
  logic [DW-1:0] prev_wd;
  logic [AW-1:0] prev_wa;

  always @(negedge clk) begin
    if (rst) begin
      check("rst_ctrl", {rd_en, wr_valid, busy, done}, 0);
      check("rst_addr", {rd_addr, wr_addr}, 0);
      check("rst_wdata", wr_data, 0);
      exp_rd.delete();
      exp_wa.delete();
      exp_wd.delete();
      reads      = 0;
      accepts    = 0;
      prev_stall = 1'b0;
    end else begin
      if (prev_stall) begin
        check("stall_valid", wr_valid, 1);
        check("stall_data", wr_data, prev_wd);
        check("stall_addr", wr_addr, prev_wa);
      end
      if (rd_en) begin
        check("rd_expected", exp_rd.size() != 0, 1);
        if (exp_rd.size() != 0) check("rd_addr", rd_addr, exp_rd.pop_front());
        rd_log_addr.push_back(rd_addr);
        rd_log_cyc.push_back(cyc);
        reads++;
        check("outstanding", (reads - accepts) <= 2, 1);
      end
      if (wr_valid) begin
        check("wr_expected", exp_wa.size() != 0, 1);
        if (exp_wa.size() != 0) begin
          check("wr_addr", wr_addr, exp_wa[0]);
          check("wr_data", wr_data, exp_wd[0]);
        end
        if (first_wv_cyc < 0) first_wv_cyc = cyc;
        if (wr_ready) begin
          if (exp_wa.size() != 0) begin
            void'(exp_wa.pop_front());
            void'(exp_wd.pop_front());
          end
          accepts++;
          wr_log_addr.push_back(wr_addr);
          wr_log_data.push_back(wr_data);
          wr_log_cyc.push_back(cyc);
        end
      end
      prev_stall = wr_valid && !wr_ready;
      prev_wd    = wr_data;
      prev_wa    = wr_addr;
      if (done) begin
        done_count++;
        done_cyc = cyc;
        check("done_busy", busy, 1);
      end
    end
  end

  task automatic fill_model(input logic [AW-1:0] s, input logic [AW-1:0] d,
                            input logic [AW-1:0] n);
    logic [AW-1:0] a;
    exp_neg = 0;
    for (int i = 0; i < int'(n); i++) begin
      a = s + AW'(i);
      exp_rd.push_back(a);
      exp_wa.push_back(d + AW'(i));
      exp_wd.push_back(relu_ref(mem[a]));
      if ($signed(mem[a]) < 0) exp_neg++;
    end
    rd_log_addr.delete();
    rd_log_cyc.delete();
    wr_log_addr.delete();
    wr_log_data.delete();
    wr_log_cyc.delete();
    reads        = 0;
    accepts      = 0;
    first_wv_cyc = -1;
  endtask

  task automatic start_job(input logic [AW-1:0] s, input logic [AW-1:0] d,
                           input logic [AW-1:0] n);
    @(posedge clk);
    #1;
    start     = 1'b1;
    src_base  = s;
    dst_base  = d;
    len       = n;
    start_cyc = cyc;
    @(posedge clk);
    #1;
    start = 1'b0;
  endtask

  task automatic run_job(input logic [AW-1:0] s, input logic [AW-1:0] d,
                         input logic [AW-1:0] n, input int mode, input int extra_start);
    int base;
    ready_mode = mode;
    base       = done_count;
    fill_model(s, d, n);
    start_job(s, d, n);
    if (extra_start > 0) begin
      repeat (extra_start) @(posedge clk);
      #1;
      check("extra_start_in_run", busy, 1);
      start    = 1'b1;
      src_base = s + AW'(100);
      len      = 7;
      @(posedge clk);
      #1;
      start = 1'b0;
    end
    for (int t = 0; t < 300 && done_count == base; t++) @(posedge clk);
    check("done_timeout", done_count != base, 1);
    repeat (3) @(posedge clk);
    #1;
    check("done_once", done_count - base, 1);
    check("rd_drained", exp_rd.size(), 0);
    check("wr_drained", exp_wa.size(), 0);
    check("idle_busy", busy, 0);
`ifdef ACT_NEGCOUNT_EN
    check("neg_count", neg_count, exp_neg);
`endif
  endtask

  initial begin
    for (int i = 0; i < (1 << AW); i++) mem[i] = 32'(i) * 32'h9E37_79B1;
    rst      = 1'b1;
    start    = 1'b0;
    src_base = '0;
    dst_base = '0;
    len      = '0;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    check("post_rst_busy", busy, 0);
    check("post_rst_valid", {rd_en, wr_valid, done}, 0);

    // Full throughput
    mem[10'h010] = 32'd5;
    mem[10'h011] = 32'hFFFF_FFFD;
    mem[10'h012] = 32'h7FFF_FFFF;
    mem[10'h013] = 32'h8000_0000;
    run_job(10'h010, 10'h200, 10'd4, 0, 0);
    check("ft_d0", wr_log_data[0], 32'd5);
    check("ft_d1", wr_log_data[1], 32'd0);
    check("ft_d2", wr_log_data[2], 32'h7FFF_FFFF);
    check("ft_d3", wr_log_data[3], 32'd0);
    check("ft_a0", wr_log_addr[0], 10'h200);
    check("ft_a3", wr_log_addr[3], 10'h203);
    check("ft_consecutive", wr_log_cyc[3] - wr_log_cyc[0], 3);
    check("ft_done_lat", done_cyc - wr_log_cyc[3], 1);
    check("ft_first_rd", rd_log_cyc[0] - start_cyc, 1);
    check("ft_first_wv", first_wv_cyc - rd_log_cyc[0], 1);
`ifdef ACT_NEGCOUNT_EN
    check("ft_neg_literal", neg_count, 2);
`endif

    // Back-pressure
    run_job(10'h040, 10'h280, 10'd6, 1, 0);
    check("bp_count", wr_log_data.size(), 6);
    check("bp_last_addr", wr_log_addr[5], 10'h285);

    // Zero length
    run_job(10'h050, 10'h2A0, 10'd0, 0, 0);
    check("zl_done_lat", (done_cyc - start_cyc) <= 2, 1);
    check("zl_no_rd", rd_log_addr.size(), 0);
    check("zl_no_wv", first_wv_cyc, -1);

    // Address wrap
    run_job(10'h3FE, 10'h100, 10'd4, 0, 0);
    check("wrap_a0", rd_log_addr[0], 10'h3FE);
    check("wrap_a1", rd_log_addr[1], 10'h3FF);
    check("wrap_a2", rd_log_addr[2], 10'h000);
    check("wrap_a3", rd_log_addr[3], 10'h001);

    // Reset in the middle of a job
    ready_mode = 0;
    fill_model(10'h080, 10'h300, 10'd8);
    start_job(10'h080, 10'h300, 10'd8);
    for (int t = 0; t < 50 && accepts < 2; t++) @(posedge clk);
    check("mid_reached_2", accepts >= 2, 1);
    #1;
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    check("mid_busy", busy, 0);
    check("mid_wvalid", wr_valid, 0);
    run_job(10'h090, 10'h310, 10'd1, 0, 0);
    check("mid_new_job_data", wr_log_data[0], relu_ref(mem[10'h090]));

    // Start while busy
    run_job(10'h0A0, 10'h340, 10'd4, 1, 2);
    check("swb_writes", wr_log_data.size(), 4);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

endmodule
